// File: rtl/orion_types.sv
// Shared types for the Orion core pipeline: stage-boundary structs, load/store
// funct3 codes and the memory-stage FSM state.
package orion_types;

  localparam int XLEN = 32;

  localparam logic [2:0] FUNCT3_LS_B  = 3'b000;
  localparam logic [2:0] FUNCT3_LS_H  = 3'b001;
  localparam logic [2:0] FUNCT3_LS_W  = 3'b010;
  localparam logic [2:0] FUNCT3_LS_BU = 3'b100;
  localparam logic [2:0] FUNCT3_LS_HU = 3'b101;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     insn;
    logic            rd_we;
    logic [XLEN-1:0] rd_v;
  } debug_t;

  typedef struct packed {
    logic            valid;
    logic [4:0]      rd_s;
    logic            rd_we;
    logic [XLEN-1:0] rd_v;
    logic [2:0]      ld_str_type;
    logic            is_load;
    logic            is_store;
    debug_t          debug;
  } ex_mem_t;

  typedef struct packed {
    logic            valid;
    logic [4:0]      rd_s;
    logic            rd_we;
    logic [XLEN-1:0] rd_v;
    debug_t          debug;
  } mem_wb_t;

  typedef struct packed {
    logic            valid;
    logic            rd_we;
    logic [4:0]      rd_s;
    logic [XLEN-1:0] rd_v;
    logic            busy;
  } mem_id_t;

  typedef enum logic {
    MEM_RUN  = 1'b0,
    MEM_WAIT = 1'b1
  } mem_state_e;

endpackage

// File: rtl/memory_load_align.sv
// Extracts the addressed byte/halfword from an aligned read word and
// sign- or zero-extends it according to the load type.
module load_align
  import orion_types::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      off,
  input  logic [2:0]      ld_str_type,
  output logic [XLEN-1:0] data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign byte_v = 8'(rdata >> {off, 3'b000});
  assign half_v = 16'(rdata >> {off[1], 4'b0000});

  // NOTE: every output of an always_comb gets a value on every path (here via
  // the default arm); a missing assignment would infer a latch.
  always_comb begin
    case (ld_str_type)
      FUNCT3_LS_B:  data = {{(XLEN-8){byte_v[7]}}, byte_v};
      FUNCT3_LS_BU: data = {{(XLEN-8){1'b0}}, byte_v};
      FUNCT3_LS_H:  data = {{(XLEN-16){half_v[15]}}, half_v};
      FUNCT3_LS_HU: data = {{(XLEN-16){1'b0}}, half_v};
      FUNCT3_LS_W:  data = rdata;
      default:      data = 'x;
    endcase
  end

endmodule

// File: rtl/memory.sv
// Memory stage: holds the EX/MEM register, stalls the front of the pipe while
// a load/store awaits its single dmem response, and aligns load data.
module memory
  import orion_types::*;
#(
  parameter int STALL_CNT_W = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  ex_mem_t                ex_mem_i,
  input  logic                   dmem_rvalid_i,
  input  logic [XLEN-1:0]        dmem_rdata_i,
  output logic                   stall_o,
  output mem_wb_t                mem_wb_o,
  output mem_id_t                mem_id_o,
  output logic [STALL_CNT_W-1:0] stall_cycles_o,
  output logic                   resp_err_o
);

  logic       valid_q;
  ex_mem_t    pay_q;
  ex_mem_t    r;
  mem_state_e state_q, state_d;
  logic       mem_op;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] rd_v_final;
  logic            rd_we_final;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)        valid_q <= 1'b0;
    else if (!stall_o) valid_q <= ex_mem_i.valid;
  end

  // NOTE: the payload is qualified by valid_q, so it is deliberately left
  // without a reset; only control state needs a known value out of reset.
  always_ff @(posedge clk_i) begin
    if (!stall_o) pay_q <= ex_mem_i;
  end

  always_comb begin
    r       = pay_q;
    r.valid = valid_q;
  end

  assign mem_op  = r.valid && (r.is_load || r.is_store);
  // A response arriving in the same cycle as the op releases it immediately.
  assign stall_o = mem_op && !dmem_rvalid_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= MEM_RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      MEM_RUN:  if (mem_op && !dmem_rvalid_i) state_d = MEM_WAIT;
      MEM_WAIT: if (dmem_rvalid_i)            state_d = MEM_RUN;
      default:  state_d = MEM_RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cycles_o <= '0;
      resp_err_o     <= 1'b0;
    end else begin
      if (stall_o)                  stall_cycles_o <= stall_cycles_o + 1'b1;
      if (dmem_rvalid_i && !mem_op) resp_err_o     <= 1'b1;
    end
  end

  load_align u_load_align (
    .rdata       (dmem_rdata_i),
    .off         (r.rd_v[1:0]),
    .ld_str_type (r.ld_str_type),
    .data        (load_data)
  );

  assign rd_we_final = r.rd_we && !r.is_store;
  assign rd_v_final  = r.is_load ? load_data : r.rd_v;

  always_comb begin
    mem_wb_o             = '0;
    mem_wb_o.valid       = r.valid && !stall_o;
    mem_wb_o.rd_s        = r.rd_s;
    mem_wb_o.rd_we       = rd_we_final;
    mem_wb_o.rd_v        = rd_v_final;
    mem_wb_o.debug       = r.debug;
    mem_wb_o.debug.rd_we = rd_we_final;
    mem_wb_o.debug.rd_v  = rd_v_final;
  end

  always_comb begin
    mem_id_o       = '0;
    mem_id_o.valid = mem_wb_o.valid;
    mem_id_o.rd_we = rd_we_final;
    mem_id_o.rd_s  = r.rd_s;
    mem_id_o.rd_v  = rd_v_final;
    mem_id_o.busy  = stall_o;
  end

endmodule

// File: tb/tb_memory.sv
// Self-checking bench for the memory stage: vector table with a retirement
// scoreboard, plus hand sequences for back-pressure, stray responses and reset.
module tb_memory;
  import orion_types::*;

  logic            clk_i = 1'b0;
  logic            rst_i;
  ex_mem_t         ex_mem_i;
  logic            dmem_rvalid_i;
  logic [XLEN-1:0] dmem_rdata_i;
  logic            stall_o;
  mem_wb_t         mem_wb_o;
  mem_id_t         mem_id_o;
  logic [31:0]     stall_cycles_o;
  logic            resp_err_o;

  always #5 clk_i = ~clk_i;

  memory #(.STALL_CNT_W(32)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .ex_mem_i       (ex_mem_i),
    .dmem_rvalid_i  (dmem_rvalid_i),
    .dmem_rdata_i   (dmem_rdata_i),
    .stall_o        (stall_o),
    .mem_wb_o       (mem_wb_o),
    .mem_id_o       (mem_id_o),
    .stall_cycles_o (stall_cycles_o),
    .resp_err_o     (resp_err_o)
  );

  typedef struct {
    logic [2:0]  f3;
    logic        ld;
    logic        st;
    logic        we;
    logic [31:0] rd_v;
    logic [31:0] rdata;
    int          lat;
    logic [31:0] exp_v;
    logic        exp_we;
  } vec_t;

  typedef struct {
    logic [4:0]  rd_s;
    logic        rd_we;
    logic [31:0] rd_v;
    logic [31:0] pc;
  } exp_t;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];
  bit   retired;
  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic ex_mem_t make_op(input logic [2:0] f3, input logic ld, input logic st,
                                      input logic we, input logic [31:0] rdv,
                                      input logic [4:0] rd, input logic [31:0] pc);
    ex_mem_t op;
    op             = '0;
    op.valid       = 1'b1;
    op.rd_s        = rd;
    op.rd_we       = we;
    op.rd_v        = rdv;
    op.ld_str_type = f3;
    op.is_load     = ld;
    op.is_store    = st;
    op.debug.pc    = pc;
    op.debug.insn  = 32'h0000_0013;
    op.debug.rd_we = we;
    op.debug.rd_v  = rdv;
    return op;
  endfunction

  task automatic monitor(input string tag);
    exp_t e;
    retired = 1'b0;
    if (mem_wb_o.valid) begin
      retired = 1'b1;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL %s unexpected_retire actual=valid required=no_retire", tag);
      end else begin
        e = sb.pop_front();
        check({tag, ".rd_s"},        32'(mem_wb_o.rd_s),        32'(e.rd_s));
        check({tag, ".rd_we"},       32'(mem_wb_o.rd_we),       32'(e.rd_we));
        check({tag, ".rd_v"},        mem_wb_o.rd_v,             e.rd_v);
        check({tag, ".pc"},          mem_wb_o.debug.pc,         e.pc);
        check({tag, ".dbg_rd_v"},    mem_wb_o.debug.rd_v,       e.rd_v);
        check({tag, ".dbg_rd_we"},   32'(mem_wb_o.debug.rd_we), 32'(e.rd_we));
        check({tag, ".id_rd_v"},     mem_id_o.rd_v,             e.rd_v);
        check({tag, ".id_valid"},    32'(mem_id_o.valid),       32'd1);
      end
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic        is_mem;
    int          lat;
    logic [31:0] cnt0;
    exp_t        e;
    string       tag;
    tag    = $sformatf("vec%0d", idx);
    is_mem = v.ld || v.st;
    lat    = is_mem ? v.lat : 0;
    cnt0   = stall_cycles_o;
    ex_mem_i = make_op(v.f3, v.ld, v.st, v.we, v.rd_v, 5'(idx + 1), 32'(idx * 4));
    e.rd_s = 5'(idx + 1); e.rd_we = v.exp_we; e.rd_v = v.exp_v; e.pc = 32'(idx * 4);
    sb.push_back(e);
    dmem_rvalid_i = 1'b0;
    tick();
    ex_mem_i = '0;
    for (int c = 0; c <= lat; c++) begin
      dmem_rvalid_i = is_mem && (c == lat);
      dmem_rdata_i  = (c == lat) ? v.rdata : 32'h0;
      #1;
      check($sformatf("%s.stall_c%0d", tag, c), 32'(stall_o), 32'(is_mem && (c < lat)));
      check($sformatf("%s.busy_c%0d", tag, c), 32'(mem_id_o.busy), 32'(is_mem && (c < lat)));
      monitor(tag);
      check($sformatf("%s.retired_c%0d", tag, c), 32'(retired), 32'(c == lat));
      if (c < lat) tick();
    end
    tick();
    dmem_rvalid_i = 1'b0;
    #1;
    check({tag, ".stall_count"}, stall_cycles_o - cnt0, 32'(lat));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ex_mem_t sw_op, add_op, lw_op;
    exp_t    e;
    logic [31:0] cnt0;

    vecs[0] = '{FUNCT3_LS_W,  1, 0, 1, 32'h0000_1000, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 1};
    vecs[1] = '{FUNCT3_LS_B,  1, 0, 1, 32'h0000_1003, 32'h80FF_0000, 3, 32'hFFFF_FF80, 1};
    vecs[2] = '{FUNCT3_LS_HU, 1, 0, 1, 32'h0000_1002, 32'h9ABC_1234, 1, 32'h0000_9ABC, 1};
    vecs[3] = '{FUNCT3_LS_H,  1, 0, 1, 32'h0000_1002, 32'h9ABC_1234, 0, 32'hFFFF_9ABC, 1};
    vecs[4] = '{FUNCT3_LS_BU, 1, 0, 1, 32'h0000_1001, 32'h1234_F678, 2, 32'h0000_00F6, 1};
    vecs[5] = '{FUNCT3_LS_B,  1, 0, 1, 32'h0000_1001, 32'h1234_F678, 0, 32'hFFFF_FFF6, 1};
    vecs[6] = '{FUNCT3_LS_H,  1, 0, 1, 32'h0000_1000, 32'h0000_8001, 1, 32'hFFFF_8001, 1};
    vecs[7] = '{FUNCT3_LS_W,  0, 1, 1, 32'h0000_2000, 32'h0000_0000, 2, 32'h0000_2000, 0};
    vecs[8] = '{FUNCT3_LS_W,  0, 0, 1, 32'h0000_0055, 32'h0000_0000, 0, 32'h0000_0055, 1};
    vecs[9] = '{FUNCT3_LS_B,  1, 0, 1, 32'h0000_2000, 32'h1234_567F, 0, 32'h0000_007F, 1};

    rst_i = 1'b0; ex_mem_i = '0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    check("rst.stall",   32'(stall_o),        32'd0);
    check("rst.valid",   32'(mem_wb_o.valid), 32'd0);
    check("rst.counter", stall_cycles_o,      32'd0);
    check("rst.resp_err", 32'(resp_err_o),    32'd0);
    tick();
    rst_i = 1'b1;
    #1;
    check("post_rst.stall", 32'(stall_o),        32'd0);
    check("post_rst.valid", 32'(mem_wb_o.valid), 32'd0);

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // Store back-to-back with an ALU op; ack two cycles late.
    sw_op  = make_op(FUNCT3_LS_W, 1'b0, 1'b1, 1'b1, 32'h0000_3000, 5'd7, 32'h100);
    add_op = make_op(FUNCT3_LS_W, 1'b0, 1'b0, 1'b1, 32'h0000_0042, 5'd8, 32'h104);
    e = '{5'd7, 1'b0, 32'h0000_3000, 32'h100}; sb.push_back(e);
    e = '{5'd8, 1'b1, 32'h0000_0042, 32'h104}; sb.push_back(e);
    ex_mem_i = sw_op;
    tick();
    ex_mem_i = add_op;
    #1;
    check("swadd.stall0", 32'(stall_o), 32'd1);
    monitor("swadd0");
    check("swadd.ret0", 32'(retired), 32'd0);
    tick();
    #1;
    check("swadd.stall1", 32'(stall_o), 32'd1);
    monitor("swadd1");
    check("swadd.ret1", 32'(retired), 32'd0);
    tick();
    dmem_rvalid_i = 1'b1;
    #1;
    check("swadd.stall2", 32'(stall_o), 32'd0);
    monitor("swadd_sw");
    check("swadd.ret_sw", 32'(retired), 32'd1);
    check("swadd.pending", 32'(sb.size()), 32'd1);
    tick();
    dmem_rvalid_i = 1'b0;
    ex_mem_i = '0;
    #1;
    check("swadd.stall3", 32'(stall_o), 32'd0);
    monitor("swadd_add");
    check("swadd.ret_add", 32'(retired), 32'd1);
    tick();
    #1;
    monitor("swadd_idle");
    check("swadd.ret_idle", 32'(retired), 32'd0);

    // Stray response with nothing outstanding.
    cnt0 = stall_cycles_o;
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = 32'hCAFE_F00D;
    #1;
    check("stray.stall", 32'(stall_o), 32'd0);
    monitor("stray");
    check("stray.no_retire", 32'(retired), 32'd0);
    tick();
    dmem_rvalid_i = 1'b0;
    #1;
    check("stray.resp_err", 32'(resp_err_o), 32'd1);
    monitor("stray1");
    check("stray.no_retire1", 32'(retired), 32'd0);
    tick();
    #1;
    check("stray.sticky", 32'(resp_err_o), 32'd1);
    check("stray.counter", stall_cycles_o, cnt0);

    // Reset while a load is outstanding.
    lw_op = make_op(FUNCT3_LS_W, 1'b1, 1'b0, 1'b1, 32'h0000_4000, 5'd9, 32'h200);
    ex_mem_i = lw_op;
    tick();
    ex_mem_i = '0;
    #1;
    check("rwait.stall", 32'(stall_o), 32'd1);
    tick();
    #1;
    check("rwait.in_wait", 32'(dut.state_q == MEM_WAIT), 32'd1);
    rst_i = 1'b0;
    #1;
    check("rwait.async_stall",   32'(stall_o),        32'd0);
    check("rwait.async_valid",   32'(mem_wb_o.valid), 32'd0);
    check("rwait.async_counter", stall_cycles_o,      32'd0);
    check("rwait.async_err",     32'(resp_err_o),     32'd0);
    tick();
    rst_i = 1'b1;
    #1;
    check("rwait.stall",   32'(stall_o),                  32'd0);
    check("rwait.run",     32'(dut.state_q == MEM_RUN),   32'd1);
    check("rwait.counter", stall_cycles_o,                32'd0);
    check("rwait.valid",   32'(mem_wb_o.valid),           32'd0);
    tick();
    #1;
    check("rwait.stall_later", 32'(stall_o),        32'd0);
    check("rwait.valid_later", 32'(mem_wb_o.valid), 32'd0);

    check("sb.empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/memory.md
MEMORY -- requirements
Module: memory

Interface
REQ-001 SHALL have parameter STALL_CNT_W, default 32, setting the width of the stall-cycle performance counter.
REQ-002 SHALL have port clk_i, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_i, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have port ex_mem_i, input, ex_mem_t, the result of the execute stage (valid, rd_s, rd_we, rd_v, ld_str_type, is_load, is_store, debug).
REQ-005 SHALL have port dmem_rvalid_i, input, 1, data-memory response or acknowledge, one pulse per request.
REQ-006 SHALL have port dmem_rdata_i, input, XLEN, aligned read word, valid when dmem_rvalid_i=1.
REQ-007 SHALL have port stall_o, output, 1, which holds the IF/ID/EX stages and gates the EX dmem_valid_o at core top.
REQ-008 SHALL have port mem_wb_o, output, mem_wb_t, the completed instruction (valid, rd_s, rd_we, rd_v, debug) sent to writeback.
REQ-009 SHALL have port mem_id_o, output, mem_id_t, forwarding to decode (valid, rd_we, rd_s, rd_v, busy).
REQ-010 SHALL have port stall_cycles_o, output, STALL_CNT_W, the count of cycles with stall_o=1.
REQ-011 SHALL have port resp_err_o, output, 1, a sticky flag for an unexpected dmem_rvalid_i.

Function
REQ-012 SHALL hold an EX/MEM register (ex_mem_t); on a clock edge with stall_o=0 it loads ex_mem_i; with stall_o=1 it holds.
REQ-013 SHALL define mem_op = reg.valid && (reg.is_load || reg.is_store); every mem_op waits for exactly one dmem_rvalid_i.
REQ-014 SHALL implement an FSM with states RUN and WAIT.
  - RUN to WAIT when mem_op && !dmem_rvalid_i.
  - WAIT to RUN on dmem_rvalid_i.
  - All other cases hold the current state.
REQ-015 SHALL accept a response in the same cycle the op reaches the register, for a zero-wait-state memory.
REQ-016 SHALL drive stall_o = mem_op && !dmem_rvalid_i, combinationally, in both RUN and WAIT.
REQ-017 SHALL drive mem_wb_o.valid = reg.valid && !stall_o, so that no bubble is duplicated and none is lost.
REQ-018 SHALL take the byte offset as off = reg.rd_v[1:0] (the ALU address).
  - FUNCT3_LS_B: sign-extend byte off.
  - FUNCT3_LS_BU: zero-extend byte off.
  - FUNCT3_LS_H: sign-extend halfword off[1].
  - FUNCT3_LS_HU: zero-extend halfword off[1].
  - FUNCT3_LS_W: the whole word.
  - Undefined ld_str_type: load result 'x.
REQ-019 SHALL drive mem_wb_o.rd_v with the extended load data for loads and reg.rd_v otherwise; stores force mem_wb_o.rd_we=0.
REQ-020 SHALL set mem_id_o.busy=stall_o; mem_id_o.valid=mem_wb_o.valid; rd_v matches mem_wb_o.rd_v.
REQ-021 SHALL treat dmem_rvalid_i while !mem_op as unexpected: it is ignored and sets resp_err_o, which stays high until reset.
REQ-022 SHALL increment stall_cycles_o each cycle stall_o=1, wrapping modulo 2^STALL_CNT_W.
REQ-023 SHALL pass debug fields through; debug.rd_v and debug.rd_we SHALL equal the final values.

Reset
REQ-024 SHALL, while rst_i=0, asynchronously set: FSM=RUN, reg.valid=0, stall_cycles_o=0, resp_err_o=0; other register fields are don't-care.
REQ-025 SHALL, during and after reset until a new op arrives, hold stall_o=0 and mem_wb_o.valid=0; a reset asserted in WAIT abandons the outstanding request.

Structure
REQ-026 SHALL place mem_wb_t, mem_id_t and the FSM state enum in orion_types; the FUNCT3_LS_* codes SHALL be reused from orion_types.
REQ-027 SHALL contain one sub-module, load_align, which is the combinational extraction/extension of REQ-018.

Verification
REQ-028 SHALL cover: LW, rd_v=0x1000, rdata=0xDEADBEEF, rvalid in the same cycle -> stall_o never 1, mem_wb_o.rd_v=0xDEADBEEF.
REQ-029 SHALL cover: LB, rd_v=0x1003, rdata=0x80FF0000, rvalid after 3 cycles -> stall_o=1 for 3 cycles, rd_v=0xFFFFFF80, stall_cycles_o=3.
REQ-030 SHALL cover: LHU, rd_v=0x1002, rdata=0x9ABC1234 -> rd_v=0x00009ABC; LH on the same data -> 0xFFFF9ABC.
REQ-031 SHALL cover: SW followed by ADD, with rvalid delayed 2 cycles -> ADD held in the register until the ack, SW rd_we=0, ADD retires the cycle after the SW.
REQ-032 SHALL cover: dmem_rvalid_i pulsed with no op -> resp_err_o=1 and sticky, mem_wb_o unaffected.
REQ-033 SHALL cover: rst_i dropped in WAIT -> next cycle stall_o=0, FSM=RUN, counter=0, mem_wb_o.valid=0.
